fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares a single `syn_FIFO` write port among `n_req` producers. Each producer presents beats with a valid/last handshake. A multi-beat packet holds the grant until its last beat, so packets are never interleaved in the FIFO. A lock watchdog releases the port if a locked producer stalls. The block sits directly in front of the FIFO: it drives `w_en`/`w_data` and observes `isFull`.

---
 rtl/fifo_wr_arbiter.sv | 141 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among n_req producers.
// Multi-beat packets hold the grant until their last beat; a watchdog breaks stalled locks.
module fifo_wr_arbiter #(
  parameter int d_width      = 8,
  parameter int n_req        = 4,
  parameter int lock_timeout = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [n_req-1:0]           req,
  input  logic [n_req-1:0]           req_last,
  input  logic [n_req*d_width-1:0]   req_data,
  output logic [n_req-1:0]           ack,
  input  logic                       fifo_full,
  output logic                       fifo_w_en,
  output logic [d_width-1:0]         fifo_w_data,
  output logic [$clog2(n_req)-1:0]   owner,
  output logic                       locked,
  output logic                       abort
);

  localparam int PW = $clog2(n_req);
  localparam int TW = $clog2(lock_timeout + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(lock_timeout - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            abort_q, abort_d;

  logic [PW-1:0]   cand;
  logic            cand_vld;
  logic            accept;

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] idx);
    if (int'(idx) == n_req - 1) rr_next = '0;
    else                        rr_next = idx + PW'(1);
  endfunction

  // Candidate selection: owner while locked, else first requester at/after rr_ptr
  always_comb begin
    int j;
    j        = 0;
    cand     = owner_q;
    cand_vld = 1'b0;
    if (state_q == LOCK) begin
      cand_vld = req[owner_q];
    end else begin
      for (int k = n_req - 1; k >= 0; k--) begin
        j = (int'(rr_ptr_q) + k) % n_req;
        if (req[j]) begin
          cand     = PW'(j);
          cand_vld = 1'b1;
        end
      end
    end
  end

  // Outputs are forced low while reset is held, independent of req
  assign accept = cand_vld & ~fifo_full & ~rst;

  always_comb begin
    ack         = '0;
    fifo_w_en   = 1'b0;
    fifo_w_data = '0;
    if (accept) begin
      ack[cand]   = 1'b1;
      fifo_w_en   = 1'b1;
      fifo_w_data = req_data[int'(cand)*d_width +: d_width];
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    timer_d  = timer_q;
    abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_last[cand]) begin
            rr_ptr_d = rr_next(cand);
          end else begin
            state_d = LOCK;
            owner_d = cand;
            timer_d = '0;
          end
        end
      end
      LOCK: begin
        if (accept) begin
          if (req_last[owner_q]) begin
            state_d  = IDLE;
            rr_ptr_d = rr_next(owner_q);
            owner_d  = '0;
            timer_d  = '0;
          end else begin
            timer_d = '0;
          end
        end else if (!req[owner_q]) begin
          // Only a silent owner counts toward the timeout; backpressure does not
          if (timer_q == TIMER_LAST) begin
            state_d  = IDLE;
            rr_ptr_d = rr_next(owner_q);
            owner_d  = '0;
            timer_d  = '0;
            abort_d  = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      timer_q  <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      timer_q  <= timer_d;
      abort_q  <= abort_d;
    end
  end

  assign owner  = owner_q;
  assign locked = (state_q == LOCK);
  assign abort  = abort_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: round robin, packet lock, backpressure, watchdog, reset, wrap.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        fifo_full;
  logic        fifo_w_en;
  logic [7:0]  fifo_w_data;
  logic [1:0]  owner;
  logic        locked;
  logic        abort;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_wr_arbiter #(.d_width(8), .n_req(4), .lock_timeout(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_last    (req_last),
    .req_data    (req_data),
    .ack         (ack),
    .fifo_full   (fifo_full),
    .fifo_w_en   (fifo_w_en),
    .fifo_w_data (fifo_w_data),
    .owner       (owner),
    .locked      (locked),
    .abort       (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    @(negedge clk);
    req = 4'b1111; req_last = 4'b1111; req_data = 32'hA3A2A1A0;
    #2;
    n_tests++;
    if ({ack, fifo_w_en, fifo_w_data, locked, owner, abort} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got ack=%b wen=%b data=%h lk=%b own=%0d ab=%b exp all 0",
               ack, fifo_w_en, fifo_w_data, locked, owner, abort);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_ack;
    logic [7:0] exp_data;
    for (int k = 0; k < 5; k++) begin
      exp_ack  = 4'b0001 << (k % 4);
      exp_data = 8'hA0 + 8'(k % 4);
      #2;
      n_tests++;
      if (ack !== exp_ack || fifo_w_data !== exp_data || fifo_w_en !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant k=%0d got ack=%b data=%h wen=%b exp ack=%b data=%h wen=1",
                 k, ack, fifo_w_data, fifo_w_en, exp_ack, exp_data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_burst_lock;
    req = 4'b0111; req_last = 4'b0101; req_data = 32'h00A211A0;
    #2;
    n_tests++;
    if (ack !== 4'b0010 || fifo_w_data !== 8'h11) begin
      n_fail++;
      $display("FAIL burst_beat1 got ack=%b data=%h exp 0010 11", ack, fifo_w_data);
    end
    @(negedge clk);
    req_data = 32'h00A212A0;
    #2;
    n_tests++;
    if (ack !== 4'b0010 || fifo_w_data !== 8'h12 || locked !== 1'b1 || owner !== 2'd1) begin
      n_fail++;
      $display("FAIL burst_beat2 got ack=%b data=%h lk=%b own=%0d exp 0010 12 1 1",
               ack, fifo_w_data, locked, owner);
    end
    @(negedge clk);
    req_last = 4'b0111; req_data = 32'h00A213A0;
    #2;
    n_tests++;
    if (ack !== 4'b0010 || fifo_w_data !== 8'h13 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_beat3 got ack=%b data=%h lk=%b exp 0010 13 1", ack, fifo_w_data, locked);
    end
    @(negedge clk);
    req = 4'b0101;
    #2;
    n_tests++;
    if (ack !== 4'b0100 || fifo_w_data !== 8'hA2 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_next2 got ack=%b data=%h lk=%b exp 0100 a2 0", ack, fifo_w_data, locked);
    end
    @(negedge clk);
    #2;
    n_tests++;
    if (ack !== 4'b0001 || fifo_w_data !== 8'hA0) begin
      n_fail++;
      $display("FAIL burst_next0 got ack=%b data=%h exp 0001 a0", ack, fifo_w_data);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    req = 4'b1000; req_last = 4'b0000; req_data = 32'h31000000;
    #2;
    n_tests++;
    if (ack !== 4'b1000 || fifo_w_data !== 8'h31) begin
      n_fail++;
      $display("FAIL bp_lock got ack=%b data=%h exp 1000 31", ack, fifo_w_data);
    end
    @(negedge clk);
    fifo_full = 1'b1; req_data = 32'h32000000;
    for (int k = 0; k < 20; k++) begin
      #2;
      n_tests++;
      if (ack !== 4'b0000 || fifo_w_en !== 1'b0 || abort !== 1'b0 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stall k=%0d got ack=%b wen=%b ab=%b lk=%b exp 0000 0 0 1",
                 k, ack, fifo_w_en, abort, locked);
      end
      @(negedge clk);
    end
    fifo_full = 1'b0; req_last = 4'b1000;
    #2;
    n_tests++;
    if (ack !== 4'b1000 || fifo_w_data !== 8'h32 || fifo_w_en !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release got ack=%b data=%h wen=%b exp 1000 32 1", ack, fifo_w_data, fifo_w_en);
    end
    @(negedge clk);
    req = 4'b0000; req_last = 4'b0000;
    #2;
    n_tests++;
    if (locked !== 1'b0 || ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_unlock got lk=%b ack=%b exp 0 0000", locked, ack);
    end
    @(negedge clk);
  endtask

  task automatic test_watchdog;
    req = 4'b0100; req_last = 4'b0000; req_data = 32'h002100A0;
    #2;
    n_tests++;
    if (ack !== 4'b0100 || fifo_w_data !== 8'h21) begin
      n_fail++;
      $display("FAIL wd_lock got ack=%b data=%h exp 0100 21", ack, fifo_w_data);
    end
    @(negedge clk);
    req = 4'b0001; req_last = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      #2;
      n_tests++;
      if (ack !== 4'b0000 || abort !== 1'b0 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL wd_wait k=%0d got ack=%b ab=%b lk=%b exp 0000 0 1", k, ack, abort, locked);
      end
      @(negedge clk);
    end
    #2;
    n_tests++;
    if (abort !== 1'b1 || ack !== 4'b0001 || locked !== 1'b0 || fifo_w_data !== 8'hA0) begin
      n_fail++;
      $display("FAIL wd_abort got ab=%b ack=%b lk=%b data=%h exp 1 0001 0 a0",
               abort, ack, locked, fifo_w_data);
    end
    @(negedge clk);
    req = 4'b0000; req_last = 4'b0000;
    #2;
    n_tests++;
    if (abort !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_abort_pulse got ab=%b exp 0", abort);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_packet;
    req = 4'b0010; req_last = 4'b0000; req_data = 32'h00004100;
    #2;
    n_tests++;
    if (ack !== 4'b0010 || fifo_w_data !== 8'h41) begin
      n_fail++;
      $display("FAIL rstm_beat1 got ack=%b data=%h exp 0010 41", ack, fifo_w_data);
    end
    @(negedge clk);
    req_data = 32'h00004200;
    #2;
    n_tests++;
    if (ack !== 4'b0010 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL rstm_beat2 got ack=%b lk=%b exp 0010 1", ack, locked);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({ack, fifo_w_en, fifo_w_data, locked, owner, abort} !== 17'd0) begin
      n_fail++;
      $display("FAIL rstm_outputs got ack=%b wen=%b data=%h lk=%b own=%0d ab=%b exp all 0",
               ack, fifo_w_en, fifo_w_data, locked, owner, abort);
    end
    @(negedge clk);
    rst = 1'b0; req = 4'b1111; req_last = 4'b1111; req_data = 32'hA3A2A1A0;
    #2;
    n_tests++;
    if (ack !== 4'b0001 || fifo_w_data !== 8'hA0) begin
      n_fail++;
      $display("FAIL rstm_first got ack=%b data=%h exp 0001 a0", ack, fifo_w_data);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    #2;
    n_tests++;
    if (ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL wrap_pre1 got ack=%b exp 0010", ack);
    end
    @(negedge clk);
    #2;
    n_tests++;
    if (ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL wrap_pre2 got ack=%b exp 0100", ack);
    end
    @(negedge clk);
    req = 4'b0010;
    #2;
    n_tests++;
    if (ack !== 4'b0010 || fifo_w_data !== 8'hA1) begin
      n_fail++;
      $display("FAIL wrap_grant got ack=%b data=%h exp 0010 a1", ack, fifo_w_data);
    end
    @(negedge clk);
    req = 4'b1111;
    #2;
    n_tests++;
    if (ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL wrap_ptr2 got ack=%b exp 0100", ack);
    end
    @(negedge clk);
    req = 4'b0000; req_last = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_backpressure();
    test_watchdog();
    test_reset_mid_packet();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
